// File: rtl/ms53l_pkg.sv
// Shared MS53L framing constants and receive FSM encoding.
// The transmit sequencer uses the same header and trailer bytes.
package ms53l_pkg;

    localparam logic [7:0] MS53L_HDR = 8'h51;
    localparam logic [7:0] MS53L_CR  = 8'h0D;
    localparam logic [7:0] MS53L_LF  = 8'h0A;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TYPE    = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_CR      = 3'd3;
    localparam logic [2:0] ERR_LF      = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [3:0] {
        S_HUNT, S_TYPE, S_ADDH, S_ADDL, S_RW,
        S_FUNC, S_LEN, S_DATA, S_CR, S_LF
    } rx_state_e;

endpackage

// File: rtl/ms53l_rx_timeout.sv
// Inter-byte watchdog: saturating counter, cleared by every byte strobe,
// counting only while a frame is open.
module ms53l_rx_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/ms53l_frame_rx.sv
// MS53L response-frame parser: hunts for the header, collects fields into
// shadow registers and publishes them only once the CR/LF trailer checks out.
module ms53l_frame_rx
    import ms53l_pkg::*;
#(
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] EXP_TYPE    = 8'h0B
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [2:0]           err_code,
    output logic [7:0]           s_type,
    output logic [15:0]          s_addr,
    output logic [7:0]           s_rw,
    output logic [7:0]           s_func,
    output logic [7:0]           s_len,
    output logic [MAX_LEN*8-1:0] s_payload,
    output logic                 busy
);
    localparam int IDX_W = $clog2(MAX_LEN) + 1;

    rx_state_e            state, state_next;
    logic                 expired, timer_en;
    logic [7:0]           type_sh, addh_sh, addl_sh, rw_sh, func_sh, len_sh;
    logic [MAX_LEN*8-1:0] pay_sh;
    logic [IDX_W-1:0]     idx;
    logic                 last_data, len_bad;
    logic                 err_set, valid_set;
    logic [2:0]           err_val;

    assign timer_en  = (state != S_HUNT);
    assign busy      = (state != S_HUNT);
    assign last_data = (8'(idx) == len_sh - 8'd1);
    assign len_bad   = (rx_data > 8'(MAX_LEN));

    ms53l_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_done),
        .enable  (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_HUNT;
        else     state <= state_next;
    end

    // A byte strobe always takes precedence over an expiring timer.
    always_comb begin
        state_next = state;
        if (rx_done) begin
            case (state)
                S_HUNT: if (rx_data == MS53L_HDR) state_next = S_TYPE;
                S_TYPE: state_next = (rx_data == EXP_TYPE) ? S_ADDH : S_HUNT;
                S_ADDH: state_next = S_ADDL;
                S_ADDL: state_next = S_RW;
                S_RW:   state_next = S_FUNC;
                S_FUNC: state_next = S_LEN;
                S_LEN: begin
                    if (len_bad)              state_next = S_HUNT;
                    else if (rx_data == 8'd0) state_next = S_CR;
                    else                      state_next = S_DATA;
                end
                S_DATA: if (last_data) state_next = S_CR;
                S_CR:   state_next = (rx_data == MS53L_CR) ? S_LF : S_HUNT;
                S_LF:   state_next = S_HUNT;
                default: state_next = S_HUNT;
            endcase
        end else if (state != S_HUNT && expired) begin
            state_next = S_HUNT;
        end
    end

    always_comb begin
        err_set   = 1'b0;
        err_val   = ERR_NONE;
        valid_set = 1'b0;
        if (rx_done) begin
            case (state)
                S_TYPE: if (rx_data != EXP_TYPE) begin err_set = 1'b1; err_val = ERR_TYPE; end
                S_LEN:  if (len_bad)             begin err_set = 1'b1; err_val = ERR_LEN;  end
                S_CR:   if (rx_data != MS53L_CR) begin err_set = 1'b1; err_val = ERR_CR;   end
                S_LF: begin
                    if (rx_data == MS53L_LF) valid_set = 1'b1;
                    else begin err_set = 1'b1; err_val = ERR_LF; end
                end
                default: ;
            endcase
        end else if (state != S_HUNT && expired) begin
            err_set = 1'b1;
            err_val = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
            s_type      <= '0;
            s_addr      <= '0;
            s_rw        <= '0;
            s_func      <= '0;
            s_len       <= '0;
            s_payload   <= '0;
            type_sh     <= '0;
            addh_sh     <= '0;
            addl_sh     <= '0;
            rw_sh       <= '0;
            func_sh     <= '0;
            len_sh      <= '0;
            pay_sh      <= '0;
            idx         <= '0;
        end else begin
            frame_valid <= valid_set;
            frame_err   <= err_set;
            if (err_set) err_code <= err_val;
            if (valid_set) begin
                s_type    <= type_sh;
                s_addr    <= {addh_sh, addl_sh};
                s_rw      <= rw_sh;
                s_func    <= func_sh;
                s_len     <= len_sh;
                s_payload <= pay_sh;
            end
            if (rx_done) begin
                case (state)
                    S_TYPE: type_sh <= rx_data;
                    S_ADDH: addh_sh <= rx_data;
                    S_ADDL: addl_sh <= rx_data;
                    S_RW:   rw_sh   <= rx_data;
                    S_FUNC: func_sh <= rx_data;
                    // Payload is cleared even for len==0 so unused lanes read 0.
                    S_LEN: begin
                        len_sh <= rx_data;
                        pay_sh <= '0;
                        idx    <= '0;
                    end
                    S_DATA: begin
                        for (int i = 0; i < MAX_LEN; i++)
                            if (idx == IDX_W'(i)) pay_sh[i*8 +: 8] <= rx_data;
                        idx <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ms53l_frame_rx.sv
// Directed bench for ms53l_frame_rx: a table of byte sequences with expected
// field outputs, then hand-written timeout and mid-frame reset sequences.
module tb_ms53l_frame_rx;
    localparam int MAX_LEN = 4;
    localparam int TO      = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        frame_valid, frame_err, busy;
    logic [2:0]  err_code;
    logic [7:0]  s_type, s_rw, s_func, s_len;
    logic [15:0] s_addr;
    logic [31:0] s_payload;

    int checks = 0;
    int errors = 0;
    int nv = 0, ne = 0, excl_bad = 0;

    ms53l_frame_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO), .EXP_TYPE(8'h0B)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code),
        .s_type(s_type), .s_addr(s_addr), .s_rw(s_rw), .s_func(s_func),
        .s_len(s_len), .s_payload(s_payload), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) nv++;
        if (frame_err) ne++;
        if (frame_valid && frame_err) excl_bad++;
    end

    // seq holds the bytes right-justified: the last byte sent is seq[7:0].
    typedef struct {
        int           n;
        logic [127:0] seq;
        logic         exp_valid;
        logic         exp_err;
        logic [2:0]   code;
        logic [7:0]   typ;
        logic [15:0]  addr;
        logic [7:0]   rw;
        logic [7:0]   func;
        logic [7:0]   len;
        logic [31:0]  pay;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic apply(input vec_t v, input string tag);
        int v0 = nv;
        int e0 = ne;
        for (int k = 0; k < v.n; k++) send(v.seq[(v.n-1-k)*8 +: 8]);
        repeat (2) @(negedge clk);
        #1;
        chk({tag, " valid_pulses"}, 32'(nv - v0), 32'(v.exp_valid));
        chk({tag, " err_pulses"},   32'(ne - e0), 32'(v.exp_err));
        chk({tag, " err_code"},     32'(err_code), 32'(v.code));
        chk({tag, " s_type"},       32'(s_type),   32'(v.typ));
        chk({tag, " s_addr"},       32'(s_addr),   32'(v.addr));
        chk({tag, " s_rw"},         32'(s_rw),     32'(v.rw));
        chk({tag, " s_func"},       32'(s_func),   32'(v.func));
        chk({tag, " s_len"},        32'(s_len),    32'(v.len));
        chk({tag, " s_payload"},    s_payload,     v.pay);
        chk({tag, " busy"},         32'(busy),     32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, " frame_err"},   32'(frame_err),   32'd0);
        chk({tag, " err_code"},    32'(err_code),    32'd0);
        chk({tag, " s_type"},      32'(s_type),      32'd0);
        chk({tag, " s_addr"},      32'(s_addr),      32'd0);
        chk({tag, " s_rw"},        32'(s_rw),        32'd0);
        chk({tag, " s_func"},      32'(s_func),      32'd0);
        chk({tag, " s_len"},       32'(s_len),       32'd0);
        chk({tag, " s_payload"},   s_payload,        32'd0);
        chk({tag, " busy"},        32'(busy),        32'd0);
    endtask

    initial begin
        vec_t v;
        int   e0;

        // Payload byte 0 lands in bits [7:0], so data 00 64 reads 0x00006400.
        vt[0] = '{11, 128'h510B000100050200640D0A,     1'b1, 1'b0, 3'd0, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'h02, 32'h00006400};
        vt[1] = '{12, 128'hAA55510B00010005017F0D0A,   1'b1, 1'b0, 3'd0, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'h01, 32'h0000007F};
        vt[2] = '{2,  128'h510C,                       1'b0, 1'b1, 3'd1, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'h01, 32'h0000007F};
        vt[3] = '{7,  128'h510B0001000505,             1'b0, 1'b1, 3'd2, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'h01, 32'h0000007F};
        vt[4] = '{9,  128'h510B00010005000D0B,         1'b0, 1'b1, 3'd4, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'h01, 32'h0000007F};
        vt[5] = '{9,  128'h510B0001000501AA0E,         1'b0, 1'b1, 3'd3, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'h01, 32'h0000007F};
        vt[6] = '{9,  128'h510B12340107000D0A,         1'b1, 1'b0, 3'd3, 8'h0B, 16'h1234, 8'h01, 8'h07, 8'h00, 32'h00000000};
        vt[7] = '{13, 128'h510B0002000304112233440D0A, 1'b1, 1'b0, 3'd3, 8'h0B, 16'h0002, 8'h00, 8'h03, 8'h04, 32'h44332211};
        vt[8] = '{11, 128'h510B515100050251520D0A,     1'b1, 1'b0, 3'd3, 8'h0B, 16'h5151, 8'h00, 8'h05, 8'h02, 32'h00005251};
        vt[9] = '{10, 128'h51510B00010005000D0A,       1'b0, 1'b1, 3'd1, 8'h0B, 16'h5151, 8'h00, 8'h05, 8'h02, 32'h00005251};

        rst = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) apply(vt[i], $sformatf("vec%0d", i));

        // Timeout: last strobe clears the timer; the error lands exactly TO edges later.
        e0 = ne;
        send(8'h51); send(8'h0B); send(8'h00);
        repeat (TO - 1) @(negedge clk);
        #1;
        chk("timeout early_err", 32'(ne - e0), 32'd0);
        chk("timeout busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("timeout err_pulse", 32'(ne - e0), 32'd1);
        chk("timeout err_code", 32'(err_code), 32'd5);
        chk("timeout busy_after", 32'(busy), 32'd0);
        chk("timeout s_addr_held", 32'(s_addr), 32'h5151);
        v = vt[0];
        v.code = 3'd5;
        apply(v, "after_timeout");

        // Reset mid-frame aborts silently.
        e0 = ne;
        send(8'h51); send(8'h0B); send(8'h00);
        chk("midrst busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_zero("midrst");
        chk("midrst no_err_pulse", 32'(ne - e0), 32'd0);
        rst = 1'b0;
        apply(vt[0], "after_reset");

        chk("valid_err_exclusive", 32'(excl_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
